// File: rtl/diff_dec_pkg.sv
// Shared types for the diff_decoder frame arbiter: IQ sample layout, Q1.15 unity and arbiter states.
package diff_dec_pkg;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq16_t;

  localparam logic signed [15:0] ONE_Q15 = 16'sd32767;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    STREAM,
    DISCARD,
    DRAIN
  } arb_state_t;

  // Modulo for an index known to be below 2*n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/diff_dec_frame_arb_rr.sv
// Combinational round-robin pick: the first requester after last_id wins,
// last_id itself has the lowest priority.
module rr_arbiter
  import diff_dec_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_any
);

  // Walk offsets from farthest to nearest so the nearest requester overrides.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (i == rr_wrap(int'(last_id) + k, N_SRC) && req[i]) begin
          grant_id  = ID_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/diff_dec_frame_arb.sv
// Frame-granular round-robin arbiter sharing one diff_decoder; soft-resets the decoder before each frame.
// Optional per-source frame and truncation counters are built when DIFF_DEC_ARB_STATS_EN is defined.
module diff_dec_frame_arb
  import diff_dec_pkg::*;
#(
  parameter int N_SRC      = 2,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_LEN    = 4096,
  parameter int ID_W       = $clog2(N_SRC)
) (
  input  logic                    clk_bb,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_last,
  output logic                    dec_in_valid,
  input  logic                    dec_in_ready,
  output logic [DATA_W-1:0]       dec_in_data,
  output logic                    dec_in_last,
  input  logic                    dec_out_valid,
  input  logic                    dec_out_ready,
  input  logic                    dec_out_last,
  output logic                    dec_sw_reset,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy,
  output logic                    trunc_pulse,
  output logic [N_SRC*16-1:0]     frame_cnt,
  output logic [15:0]             trunc_cnt
);

  localparam int               LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_CAP  = LEN_W'(MAX_LEN - 1);
  localparam logic [3:0]       RST_LAST = 4'(RST_CYCLES - 1);

  arb_state_t       state_q;
  logic [ID_W-1:0]  cur_id_q;
  logic [ID_W-1:0]  last_id_q;
  logic [3:0]       rst_cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             drain_seen_q;
  logic             dec_sw_reset_q;
  logic             busy_q;
  logic             trunc_pulse_q;

  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              cur_valid;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;
  logic              forced_last;
  logic              out_last_hs;
  logic              stream_hs;
  logic              discard_hs;
  logic              frame_done;
  logic              trunc_evt;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (src_valid),
    .last_id   (last_id_q),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Lane of the source that currently owns the decoder.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cur_id_q == ID_W'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign forced_last = (len_q == LEN_CAP);
  assign out_last_hs = dec_out_valid & dec_out_ready & dec_out_last;
  assign stream_hs   = (state_q == STREAM) & cur_valid & dec_in_ready;
  assign discard_hs  = (state_q == DISCARD) & cur_valid;
  assign trunc_evt   = stream_hs & forced_last & ~cur_last;

  // The frame is finished once its final decoded beat has left the decoder, possibly already during DISCARD.
  assign frame_done = ((state_q == DRAIN) & (out_last_hs | drain_seen_q)) |
                      (discard_hs & cur_last & (out_last_hs | drain_seen_q));

  always_comb begin
    src_ready    = '0;
    dec_in_valid = 1'b0;
    dec_in_data  = '0;
    dec_in_last  = 1'b0;
    if (state_q == STREAM) begin
      dec_in_valid = cur_valid;
      dec_in_data  = cur_data;
      dec_in_last  = cur_last | forced_last;
      for (int i = 0; i < N_SRC; i++) begin
        src_ready[i] = (cur_id_q == ID_W'(i)) & dec_in_ready;
      end
    end else if (state_q == DISCARD) begin
      for (int i = 0; i < N_SRC; i++) begin
        src_ready[i] = (cur_id_q == ID_W'(i));
      end
    end
  end

  always_ff @(posedge clk_bb) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cur_id_q       <= '0;
      last_id_q      <= ID_W'(N_SRC - 1);
      rst_cnt_q      <= '0;
      len_q          <= '0;
      drain_seen_q   <= 1'b0;
      dec_sw_reset_q <= 1'b0;
      busy_q         <= 1'b0;
      trunc_pulse_q  <= 1'b0;
    end else begin
      trunc_pulse_q <= trunc_evt;
      if ((state_q == STREAM || state_q == DISCARD) && out_last_hs) begin
        drain_seen_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q        <= RESET;
            cur_id_q       <= grant_id;
            rst_cnt_q      <= '0;
            drain_seen_q   <= 1'b0;
            dec_sw_reset_q <= 1'b1;
            busy_q         <= 1'b1;
          end
        end
        RESET: begin
          rst_cnt_q <= rst_cnt_q + 4'd1;
          if (rst_cnt_q == RST_LAST) begin
            state_q        <= STREAM;
            len_q          <= '0;
            dec_sw_reset_q <= 1'b0;
          end
        end
        STREAM: begin
          if (stream_hs) begin
            len_q <= len_q + LEN_W'(1);
            if (cur_last) begin
              state_q <= DRAIN;
            end else if (forced_last) begin
              state_q <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (discard_hs && cur_last) begin
            if (frame_done) begin
              state_q   <= IDLE;
              last_id_q <= cur_id_q;
              busy_q    <= 1'b0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (frame_done) begin
            state_q   <= IDLE;
            last_id_q <= cur_id_q;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_sw_reset = dec_sw_reset_q;
  assign busy         = busy_q;
  assign trunc_pulse  = trunc_pulse_q;
  assign out_id       = busy_q ? cur_id_q : '0;

`ifdef DIFF_DEC_ARB_STATS_EN
  logic [N_SRC-1:0][CNT_W-1:0] frame_cnt_q;
  logic [N_SRC-1:0][CNT_W-1:0] frame_cnt_d;
  logic [CNT_W-1:0]            trunc_cnt_q;
  logic [CNT_W-1:0]            trunc_cnt_d;

  // Both counters wrap modulo 2^16.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q + {{(CNT_W-1){1'b0}}, trunc_pulse_q};
    for (int i = 0; i < N_SRC; i++) begin
      if (frame_done && cur_id_q == ID_W'(i)) begin
        frame_cnt_d[i] = frame_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_bb) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`else
  assign frame_cnt = '0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_diff_dec_frame_arb.sv
// Directed bench for diff_dec_frame_arb: two counting sources and a fixed-latency decoder output model.
`timescale 1ns/1ps
module tb_diff_dec_frame_arb;

  localparam int N_SRC      = 2;
  localparam int DATA_W     = 32;
  localparam int RST_CYCLES = 2;
  localparam int MAX_LEN    = 8;
  localparam int ID_W       = 1;

`ifdef DIFF_DEC_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic                    clk_bb = 1'b0;
  logic                    rst_n;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_last;
  logic                    dec_in_valid;
  logic                    dec_in_ready;
  logic [DATA_W-1:0]       dec_in_data;
  logic                    dec_in_last;
  logic                    dec_out_valid;
  logic                    dec_out_ready;
  logic                    dec_out_last;
  logic                    dec_sw_reset;
  logic [ID_W-1:0]         out_id;
  logic                    busy;
  logic                    trunc_pulse;
  logic [N_SRC*16-1:0]     frame_cnt;
  logic [15:0]             trunc_cnt;

  int assertCount = 0;
  int failCount   = 0;

  int framesLeft [N_SRC];
  int srcLen     [N_SRC];
  int beat       [N_SRC];
  int frm        [N_SRC];
  logic [DATA_W-1:0] fwdData[$];
  bit   fwdLast[$];
  int   grants[$];
  int   swLen[$];
  int   overlap, idMis, truncSeen, srcHs, outCountdown;
  bit   frameOpen, swPrev, stallOut, outDone;

  always #5 clk_bb = ~clk_bb;

  diff_dec_frame_arb #(
    .N_SRC      (N_SRC),
    .DATA_W     (DATA_W),
    .RST_CYCLES (RST_CYCLES),
    .MAX_LEN    (MAX_LEN),
    .ID_W       (ID_W)
  ) dut (
    .clk_bb        (clk_bb),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .src_last      (src_last),
    .dec_in_valid  (dec_in_valid),
    .dec_in_ready  (dec_in_ready),
    .dec_in_data   (dec_in_data),
    .dec_in_last   (dec_in_last),
    .dec_out_valid (dec_out_valid),
    .dec_out_ready (dec_out_ready),
    .dec_out_last  (dec_out_last),
    .dec_sw_reset  (dec_sw_reset),
    .out_id        (out_id),
    .busy          (busy),
    .trunc_pulse   (trunc_pulse),
    .frame_cnt     (frame_cnt),
    .trunc_cnt     (trunc_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int s, input int f, input int b);
    return {8'(s), 8'(f), 16'(b)};
  endfunction

  function automatic int qAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic driveSources();
    for (int s = 0; s < N_SRC; s++) begin
      src_valid[s] = (framesLeft[s] > 0);
      src_last[s]  = (beat[s] == srcLen[s] - 1);
      src_data[s*DATA_W +: DATA_W] = pat(s, frm[s], beat[s]);
    end
  endtask

  task automatic applyStimulus(input int s, input int nFrames, input int len);
    framesLeft[s] = nFrames;
    srcLen[s]     = len;
    beat[s]       = 0;
    frm[s]        = 0;
    driveSources();
  endtask

  task automatic resetModels();
    for (int s = 0; s < N_SRC; s++) begin
      framesLeft[s] = 0;
      srcLen[s]     = 1;
      beat[s]       = 0;
      frm[s]        = 0;
    end
    outCountdown  = 0;
    outDone       = 1'b0;
    frameOpen     = 1'b0;
    swPrev        = 1'b0;
    dec_out_valid = 1'b0;
    dec_out_last  = 1'b0;
    driveSources();
  endtask

  task automatic clearLog();
    fwdData.delete();
    fwdLast.delete();
    grants.delete();
    swLen.delete();
    overlap   = 0;
    idMis     = 0;
    truncSeen = 0;
    srcHs     = 0;
  endtask

  // One clock: observe at the falling edge, advance the models just after the rising edge.
  task automatic cycle();
    bit hs [N_SRC];
    @(negedge clk_bb);
    if (dec_in_valid && dec_in_ready) begin
      fwdData.push_back(dec_in_data);
      fwdLast.push_back(dec_in_last);
      if (32'(out_id) != 32'(dec_in_data[31:24])) idMis++;
      if (dec_in_last) outCountdown = 3;
    end
    if (dec_out_valid && dec_out_ready && dec_out_last) begin
      frameOpen = 1'b0;
      outDone   = 1'b1;
    end
    if (dec_sw_reset && !swPrev) begin
      grants.push_back(int'(out_id));
      if (frameOpen) overlap++;
      frameOpen = 1'b1;
      swLen.push_back(0);
    end
    if (dec_sw_reset && swLen.size() > 0) swLen[swLen.size()-1]++;
    swPrev = dec_sw_reset;
    if (trunc_pulse) truncSeen++;
    for (int s = 0; s < N_SRC; s++) begin
      hs[s] = src_valid[s] && src_ready[s];
      if (hs[s]) srcHs++;
    end
    @(posedge clk_bb);
    #1;
    for (int s = 0; s < N_SRC; s++) begin
      if (hs[s]) begin
        if (beat[s] == srcLen[s] - 1) begin
          beat[s] = 0;
          frm[s]++;
          framesLeft[s]--;
        end else begin
          beat[s]++;
        end
      end
    end
    if (outDone) begin
      dec_out_valid = 1'b0;
      dec_out_last  = 1'b0;
      outDone       = 1'b0;
    end
    if (outCountdown > 0) begin
      outCountdown--;
      if (outCountdown == 0) begin
        dec_out_valid = 1'b1;
        dec_out_last  = 1'b1;
      end
    end
    dec_out_ready = !stallOut;
    driveSources();
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    resetModels();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    int k = 0;
    bit done = 1'b0;
    while (k < maxCycles && !done) begin
      cycle();
      k++;
      done = (framesLeft[0] == 0) && (framesLeft[1] == 0) && !busy;
    end
    checkOutput({tag, "_timeout"}, 64'(!done), 0);
  endtask

  task automatic checkFrame(input string tag, input int s, input int n);
    int bad = 0;
    checkOutput({tag, "_beats"}, 64'(fwdData.size()), 64'(n));
    for (int b = 0; b < n && b < fwdData.size(); b++) begin
      if (fwdData[b] !== pat(s, 0, b) || fwdLast[b] !== (b == n - 1)) bad++;
    end
    checkOutput({tag, "_data"}, 64'(bad), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int k;
    rst_n         = 1'b0;
    src_valid     = '0;
    src_last      = '0;
    src_data      = '0;
    dec_in_ready  = 1'b1;
    dec_out_ready = 1'b1;
    stallOut      = 1'b0;
    resetModels();
    clearLog();
    repeat (3) cycle();

    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_sw_reset", 64'(dec_sw_reset), 0);
    checkOutput("rst_src_ready", 64'(src_ready), 0);
    checkOutput("rst_in_valid", 64'(dec_in_valid), 0);
    checkOutput("rst_in_last", 64'(dec_in_last), 0);
    checkOutput("rst_in_data", 64'(dec_in_data), 0);
    checkOutput("rst_out_id", 64'(out_id), 0);
    checkOutput("rst_trunc", 64'(trunc_pulse), 0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 0);
    checkOutput("rst_trunc_cnt", 64'(trunc_cnt), 0);
    rst_n = 1'b1;
    cycle();

    $display("[TB] single source, 4-beat frame");
    clearLog();
    applyStimulus(0, 1, 4);
    waitDone("t1", 100);
    checkOutput("t1_grants", 64'(grants.size()), 1);
    checkOutput("t1_grant0", 64'(qAt(grants, 0)), 0);
    checkOutput("t1_sw_cycles", 64'(qAt(swLen, 0)), 2);
    checkFrame("t1", 0, 4);
    checkOutput("t1_out_id", 64'(idMis), 0);
    checkOutput("t1_trunc", 64'(truncSeen), 0);
    checkOutput("t1_frame_cnt0", 64'(frame_cnt[15:0]), 64'(STATS));

    $display("[TB] two sources, 3 frames each");
    resetDut();
    clearLog();
    applyStimulus(0, 3, 3);
    applyStimulus(1, 3, 3);
    waitDone("t2", 400);
    checkOutput("t2_grants", 64'(grants.size()), 6);
    bad = 0;
    for (int i = 0; i < 6; i++) if (qAt(grants, i) != i % 2) bad++;
    checkOutput("t2_order", 64'(bad), 0);
    checkOutput("t2_overlap", 64'(overlap), 0);
    bad = 0;
    for (int i = 0; i < 6; i++) if (qAt(swLen, i) != RST_CYCLES) bad++;
    checkOutput("t2_sw_cycles", 64'(bad), 0);
    checkOutput("t2_beats", 64'(fwdData.size()), 18);
    bad = 0;
    for (int i = 0; i < 18 && i < fwdData.size(); i++) begin
      if (fwdData[i] !== pat((i / 3) % 2, i / 6, i % 3) || fwdLast[i] !== (i % 3 == 2)) bad++;
    end
    checkOutput("t2_data", 64'(bad), 0);
    checkOutput("t2_out_id", 64'(idMis), 0);
    checkOutput("t2_frame_cnt", 64'(frame_cnt), 64'(STATS * 32'h0003_0003));

    $display("[TB] over-long frame is truncated at MAX_LEN");
    clearLog();
    applyStimulus(0, 1, 12);
    waitDone("t3", 200);
    checkOutput("t3_grant0", 64'(qAt(grants, 0)), 0);
    checkFrame("t3", 0, 8);
    checkOutput("t3_src_hs", 64'(srcHs), 12);
    checkOutput("t3_trunc_pulse", 64'(truncSeen), 1);
    checkOutput("t3_trunc_cnt", 64'(trunc_cnt), 64'(STATS));

    $display("[TB] decoder output stalled after last input");
    clearLog();
    stallOut      = 1'b1;
    dec_out_ready = 1'b0;
    applyStimulus(1, 1, 2);
    k = 0;
    while (k < 60 && framesLeft[1] != 0) begin
      cycle();
      k++;
    end
    checkOutput("t4_input_timeout", 64'(framesLeft[1] != 0), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!busy) bad++;
    end
    checkOutput("t4_busy_held", 64'(bad), 0);
    checkOutput("t4_out_pending", 64'(frameOpen), 1);
    stallOut = 1'b0;
    waitDone("t4", 50);
    checkOutput("t4_released", 64'(frameOpen), 0);
    checkOutput("t4_grant0", 64'(qAt(grants, 0)), 1);

    $display("[TB] reset in the middle of a source 1 frame");
    clearLog();
    applyStimulus(1, 1, 6);
    k = 0;
    while (k < 60 && fwdData.size() < 2) begin
      cycle();
      k++;
    end
    checkOutput("t5_stream_timeout", 64'(fwdData.size() < 2), 0);
    checkOutput("t5_owner", 64'(out_id), 1);
    rst_n = 1'b0;
    cycle();
    checkOutput("t5_busy", 64'(busy), 0);
    checkOutput("t5_sw_reset", 64'(dec_sw_reset), 0);
    checkOutput("t5_src_ready", 64'(src_ready), 0);
    checkOutput("t5_in_valid", 64'(dec_in_valid), 0);
    checkOutput("t5_in_data", 64'(dec_in_data), 0);
    checkOutput("t5_out_id", 64'(out_id), 0);
    checkOutput("t5_counters", 64'({frame_cnt, trunc_cnt}), 0);
    resetModels();
    cycle();
    rst_n = 1'b1;
    cycle();
    clearLog();
    applyStimulus(0, 1, 2);
    applyStimulus(1, 1, 2);
    waitDone("t5", 100);
    checkOutput("t5_grant0", 64'(qAt(grants, 0)), 0);
    checkOutput("t5_grant1", 64'(qAt(grants, 1)), 1);
    checkOutput("t5_frame_cnt", 64'(frame_cnt), 64'(STATS * 32'h0001_0001));

    $display("[TB] real last exactly on beat MAX_LEN");
    clearLog();
    applyStimulus(0, 1, 8);
    waitDone("t6", 100);
    checkFrame("t6", 0, 8);
    checkOutput("t6_src_hs", 64'(srcHs), 8);
    checkOutput("t6_trunc_pulse", 64'(truncSeen), 0);
    checkOutput("t6_trunc_cnt", 64'(trunc_cnt), 0);
    checkOutput("t6_frame_cnt0", 64'(frame_cnt[15:0]), 64'(STATS * 2));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/diff_dec_frame_arb.md
# diff_dec_frame_arb

Frame-granular round-robin arbiter that shares one `diff_decoder` datapath between `N_SRC` encoded-symbol sources. It grants whole frames (TLAST-delimited), pulses the decoder's soft reset before every frame so each frame restarts from y[-1] = (+1, 0), and tags decoder output with the owning source ID. It waits until the decoder has released the final decoded beat of the frame before it grants another source. It sits between the symbol-source muxes and the decoder's input AXIS port and CTRL soft-reset bit.

## Interface
Parameters:
- `N_SRC`, default 2: number of requesting sources, 2..8.
- `DATA_W`, default 32: symbol width, carried as {I[15:0], Q[15:0]} in Q1.15.
- `RST_CYCLES`, default 2: number of cycles `dec_sw_reset` is held high, 1..15.
- `MAX_LEN`, default 4096: maximum number of symbols per frame, ≥2.
- `ID_W`, default `$clog2(N_SRC)`: width of the source ID.

Ports:
- `clk_bb`  in  1  the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `src_valid`  in  N_SRC  per-source valid.
- `src_ready`  out  N_SRC  per-source ready.
- `src_data`  in  N_SRC*DATA_W  per-source data; source i occupies slice [i*DATA_W +: DATA_W].
- `src_last`  in  N_SRC  per-source end-of-frame.
- `dec_in_valid` / `dec_in_ready` / `dec_in_data` / `dec_in_last`  out/in/out/out  1/1/DATA_W/1  input stream to the decoder.
- `dec_out_valid`, `dec_out_ready`, `dec_out_last`  in  1 each  decoder output handshake, monitored only.
- `dec_sw_reset`  out  1  decoder soft-reset request.
- `out_id`  out  ID_W  source that owns the current decoder output.
- `busy`  out  1  high whenever the state is not IDLE.
- `trunc_pulse`  out  1  one-cycle flag: a frame was forcibly terminated.
- `frame_cnt`  out  N_SRC*16  per-source count of completed frames (see Configuration).
- `trunc_cnt`  out  16  count of truncated frames (see Configuration).

## Operation
- States: IDLE, RESET, STREAM, DISCARD, DRAIN.
- **IDLE**
  - If any `src_valid` is high, grant round-robin, searching from `last_id+1` modulo N_SRC.
  - Latch the granted index into `cur_id`, clear `rst_cnt`, go to RESET.
  - `src_ready` = 0.
- **RESET**
  - `dec_sw_reset` = 1; `rst_cnt` increments each cycle.
  - When `rst_cnt == RST_CYCLES-1`, go to STREAM and clear `len`.
  - All `src_ready` = 0; `dec_in_valid` = 0.
- **STREAM** (combinational pass-through of source `cur_id`)
  - `dec_in_valid` = `src_valid[cur_id]`; `src_ready[cur_id]` = `dec_in_ready`; all other `src_ready` = 0.
  - `dec_in_data` = slice `cur_id` of `src_data`.
  - `dec_in_last` = `src_last[cur_id]` OR (`len == MAX_LEN-1`).
  - Each handshake increments `len`.
  - Handshake with `src_last` high → DRAIN.
  - Handshake with the forced last and `src_last` low → DISCARD; `trunc_pulse` for one cycle.
- **DISCARD**
  - `src_ready[cur_id]` = 1; `dec_in_valid` = 0.
  - Drops source beats until a handshake with `src_last` high, then → DRAIN.
- **DRAIN**
  - Wait for `dec_out_valid & dec_out_ready & dec_out_last`, then set `last_id = cur_id` and go to IDLE.
  - If that event already occurred during DISCARD (sticky flag `drain_seen`), go straight from DISCARD to IDLE.
- `out_id` = `cur_id` from the RESET state until DRAIN exits.
- Width rules:
  - `len` is $clog2(MAX_LEN+1) bits and never wraps, because a forced last caps it.
  - Counters are 16 bits and wrap modulo 2^16.
- A source that drops `src_valid` mid-frame stalls STREAM indefinitely; there is no timeout.

## Timing
- Reset values:
  - State IDLE; `last_id` = N_SRC-1, so source 0 wins first.
  - `cur_id` = 0, and every output is 0: `out_id`, `src_ready`, `dec_in_*`, `dec_sw_reset`, `busy`, `trunc_pulse`, counters.
- Grant timeline:
  - `src_valid` seen in IDLE at cycle 0.
  - `dec_sw_reset` high in cycles 1..RST_CYCLES.
  - First symbol can hand off in cycle RST_CYCLES+1.
- STREAM adds zero latency and no bubbles.
- Minimum gap between frames: DRAIN exit, then 1 IDLE cycle, then RST_CYCLES cycles.
- In STREAM, a forced last and a real `src_last` on the same beat count as a normal last: no truncation, no pulse.
- `rst_n` low mid-frame: all state returns to the reset values on the next edge. The decoder must be reset alongside.

## Configuration
- Macro `DIFF_DEC_ARB_STATS_EN`.
- Defined:
  - `frame_cnt[i]` increments on DRAIN exit for source i.
  - `trunc_cnt` increments with each `trunc_pulse`.
- Undefined: the counter logic is omitted and `frame_cnt`/`trunc_cnt` are tied to 0. The ports remain present.

## Structure
- Package `diff_dec_pkg`:
  - `iq16_t`
  - `ONE_Q15` (32767)
  - `arb_state_t` enum (IDLE, RESET, STREAM, DISCARD, DRAIN)
- Sub-module `rr_arbiter`:
  - Pure combinational round-robin pick.
  - Inputs: request vector, `last_id`.
  - Outputs: `grant_id`, `grant_any`.

## Test plan
- Single source, frame of 4 beats: `dec_sw_reset` high for exactly 2 cycles, 4 beats pass unchanged with `dec_in_last` on beat 4, `out_id` = 0, `frame_cnt[0]` = 1.
- Both sources always valid, 3 frames each: grants alternate 0,1,0,1,0,1, and no new reset pulse occurs before the prior frame's `dec_out_last` handshake.
- `MAX_LEN` = 8, source sends 12 beats: 8 reach the decoder with `dec_in_last` on beat 8, 4 are dropped, `trunc_pulse` fires once, `trunc_cnt` = 1.
- Decoder output stalled (`dec_out_ready` = 0 for 20 cycles after the last input): the arbiter stays in DRAIN and `busy` = 1 until the last-beat handshake.
- `rst_n` asserted mid-STREAM with source 1 granted: next cycle all outputs are 0, and the next grant goes to source 0.
- `MAX_LEN` = 8, real `src_last` on beat 8: no truncation, `trunc_pulse` stays 0, the frame ends normally.
